// File: rtl/dbg_state_dumper_if.sv
// Dump stream port of the debug state dumper: one 32-bit word per valid/ready handshake,
// classified by a 2-bit tag and terminated by a last flag.
interface dbg_state_dumper_if;
  logic        out_valid_o;
  logic        out_ready_i;
  logic [31:0] out_data_o;
  logic [1:0]  out_tag_o;
  logic        out_last_o;

  modport master (
    output out_valid_o,
    output out_data_o,
    output out_tag_o,
    output out_last_o,
    input  out_ready_i
  );

  modport slave (
    input  out_valid_o,
    input  out_data_o,
    input  out_tag_o,
    input  out_last_o,
    output out_ready_i
  );
endinterface

// File: rtl/dbg_state_dumper.sv
// Debug readout unit: live cycle/stall/flush counters plus an on-request stream of frozen
// counter snapshots, all architectural registers and the first data-memory words.
module dbg_state_dumper #(
  parameter int NUM_REGS      = 32,
  parameter int NUM_MEM_WORDS = 8,
  parameter int CNT_W         = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 stall_i,
  input  logic                 flush_i,
  input  logic                 dump_req_i,
  output logic                 busy_o,
  output logic [4:0]           reg_addr_o,
  input  logic [31:0]          reg_data_i,
  output logic [31:0]          mem_addr_o,
  input  logic [31:0]          mem_data_i,
  dbg_state_dumper_if.master   dump_if,
  output logic [CNT_W-1:0]     cycle_cnt_o,
  output logic [CNT_W-1:0]     stall_cnt_o,
  output logic [CNT_W-1:0]     flush_cnt_o
);

  localparam int IDX_MAX = (NUM_REGS > NUM_MEM_WORDS) ? NUM_REGS : NUM_MEM_WORDS;
  localparam int IDX_W   = $clog2(IDX_MAX + 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CNT  = 2'd1,
    ST_REG  = 2'd2,
    ST_MEM  = 2'd3
  } state_t;

  typedef struct packed {
    state_t           st;
    logic [IDX_W-1:0] idx;
  } pos_t;

  // Position of the word that follows p in the dump order; the last memory word wraps to IDLE.
  function automatic pos_t pos_next(input pos_t p);
    pos_t n;
    n.st  = ST_IDLE;
    n.idx = '0;
    case (p.st)
      ST_IDLE: n.st = ST_CNT;
      ST_CNT: begin
        if (p.idx == IDX_W'(2)) begin
          n.st = ST_REG;
        end else begin
          n.st  = ST_CNT;
          n.idx = p.idx + IDX_W'(1);
        end
      end
      ST_REG: begin
        if (p.idx == IDX_W'(NUM_REGS - 1)) begin
          n.st = ST_MEM;
        end else begin
          n.st  = ST_REG;
          n.idx = p.idx + IDX_W'(1);
        end
      end
      ST_MEM: begin
        if (p.idx != IDX_W'(NUM_MEM_WORDS - 1)) begin
          n.st  = ST_MEM;
          n.idx = p.idx + IDX_W'(1);
        end else begin
          n.st = ST_IDLE;
        end
      end
      default: n.st = ST_IDLE;
    endcase
    return n;
  endfunction

  state_t             state_r;
  logic [IDX_W-1:0]   idx_r;
  logic               valid_r;
  logic               busy_r;
  logic               last_r;
  logic [31:0]        data_r;
  logic [1:0]         tag_r;
  logic [4:0]         reg_addr_r;
  logic [31:0]        mem_addr_r;
  logic [CNT_W-1:0]   cycle_cnt_r;
  logic [CNT_W-1:0]   stall_cnt_r;
  logic [CNT_W-1:0]   flush_cnt_r;
  logic [CNT_W-1:0]   snap_stall_r;
  logic [CNT_W-1:0]   snap_flush_r;

  pos_t               cur_s;
  pos_t               nxt_s;
  pos_t               fol_s;
  logic [31:0]        word_s;
  logic [1:0]         tag_s;
  logic               nxt_last_s;
  logic               advance_s;

  // nxt_s is the word to load at the next advance; fol_s is the one after it, whose
  // address must be presented so its read data is ready when it gets loaded.
  assign cur_s      = '{st: state_r, idx: idx_r};
  assign nxt_s      = pos_next(cur_s);
  assign fol_s      = pos_next(nxt_s);
  assign nxt_last_s = (nxt_s.st == ST_MEM) && (nxt_s.idx == IDX_W'(NUM_MEM_WORDS - 1));
  assign advance_s  = (state_r == ST_IDLE) ? dump_req_i : (valid_r && dump_if.out_ready_i);

  // Select the word and tag for the next load. CNT index 0 is only ever reached from IDLE,
  // so it takes the live cycle counter, which is exactly its pre-increment snapshot.
  always_comb begin
    word_s = 32'd0;
    tag_s  = 2'd0;
    case (nxt_s.st)
      ST_CNT: begin
        tag_s = 2'd0;
        case (nxt_s.idx)
          IDX_W'(0): word_s = 32'(cycle_cnt_r);
          IDX_W'(1): word_s = 32'(snap_stall_r);
          default:   word_s = 32'(snap_flush_r);
        endcase
      end
      ST_REG: begin
        tag_s  = 2'd1;
        word_s = reg_data_i;
      end
      ST_MEM: begin
        tag_s  = 2'd2;
        word_s = mem_data_i;
      end
      default: begin
        tag_s  = 2'd0;
        word_s = 32'd0;
      end
    endcase
  end

  // Performance counters, dump sequencer and the registered output word.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_r      <= ST_IDLE;
      idx_r        <= '0;
      valid_r      <= 1'b0;
      busy_r       <= 1'b0;
      last_r       <= 1'b0;
      data_r       <= 32'd0;
      tag_r        <= 2'd0;
      reg_addr_r   <= 5'd0;
      mem_addr_r   <= 32'd0;
      cycle_cnt_r  <= '0;
      stall_cnt_r  <= '0;
      flush_cnt_r  <= '0;
      snap_stall_r <= '0;
      snap_flush_r <= '0;
    end else begin
      cycle_cnt_r <= cycle_cnt_r + CNT_W'(1);
      stall_cnt_r <= stall_cnt_r + CNT_W'(stall_i && !flush_i);
      flush_cnt_r <= flush_cnt_r + CNT_W'(flush_i);
      if (advance_s) begin
        if (state_r == ST_IDLE) begin
          snap_stall_r <= stall_cnt_r;
          snap_flush_r <= flush_cnt_r;
        end
        if (last_r) begin
          state_r    <= ST_IDLE;
          idx_r      <= '0;
          valid_r    <= 1'b0;
          busy_r     <= 1'b0;
          last_r     <= 1'b0;
          reg_addr_r <= 5'd0;
          mem_addr_r <= 32'd0;
        end else begin
          state_r    <= nxt_s.st;
          idx_r      <= nxt_s.idx;
          valid_r    <= 1'b1;
          busy_r     <= 1'b1;
          last_r     <= nxt_last_s;
          data_r     <= word_s;
          tag_r      <= tag_s;
          reg_addr_r <= (fol_s.st == ST_REG) ? 5'(fol_s.idx) : 5'd0;
          mem_addr_r <= (fol_s.st == ST_MEM) ? 32'({fol_s.idx, 2'b00}) : 32'd0;
        end
      end
    end
  end

  assign busy_o              = busy_r;
  assign reg_addr_o          = reg_addr_r;
  assign mem_addr_o          = mem_addr_r;
  assign dump_if.out_valid_o = valid_r;
  assign dump_if.out_data_o  = data_r;
  assign dump_if.out_tag_o   = tag_r;
  assign dump_if.out_last_o  = last_r;
  assign cycle_cnt_o         = cycle_cnt_r;
  assign stall_cnt_o         = stall_cnt_r;
  assign flush_cnt_o         = flush_cnt_r;

endmodule

// File: tb/tb_dbg_state_dumper.sv
// Directed bench for dbg_state_dumper: counting, full dump, back-pressure, ignored and
// held requests, reset mid-dump, and counter wrap on a 4-bit-counter instance.
module tb_dbg_state_dumper;

  logic        clk = 1'b0;
  logic        rst, rst_w;
  logic        stall, flush, dump_req;
  logic        busy, busy_w;
  logic [4:0]  reg_addr, reg_addr_w;
  logic [31:0] reg_data, mem_addr, mem_data, mem_addr_w;
  logic [31:0] cyc, stl, fl;
  logic [3:0]  cyc_w, stl_w, fl_w;
  logic [31:0] regs [0:31];
  logic [31:0] mem  [0:7];
  logic [31:0] snap;
  int unsigned edge_cnt;
  int          checks   = 0;
  int          failures = 0;

  always #5 clk = ~clk;

  dbg_state_dumper_if dif ();
  dbg_state_dumper_if wif ();

  dbg_state_dumper u_dut (
    .clk_i(clk), .rst_i(rst), .stall_i(stall), .flush_i(flush), .dump_req_i(dump_req),
    .busy_o(busy), .reg_addr_o(reg_addr), .reg_data_i(reg_data), .mem_addr_o(mem_addr),
    .mem_data_i(mem_data), .dump_if(dif), .cycle_cnt_o(cyc), .stall_cnt_o(stl),
    .flush_cnt_o(fl)
  );

  dbg_state_dumper #(.CNT_W(4)) u_wrap (
    .clk_i(clk), .rst_i(rst_w), .stall_i(1'b0), .flush_i(1'b0), .dump_req_i(1'b0),
    .busy_o(busy_w), .reg_addr_o(reg_addr_w), .reg_data_i(32'd0), .mem_addr_o(mem_addr_w),
    .mem_data_i(32'd0), .dump_if(wif), .cycle_cnt_o(cyc_w), .stall_cnt_o(stl_w),
    .flush_cnt_o(fl_w)
  );

  assign reg_data = regs[reg_addr];
  assign mem_data = (mem_addr[31:5] == 27'd0) ? mem[mem_addr[4:2]] : 32'd0;

  // Edges seen since reset release, i.e. what the cycle counter should read.
  always @(posedge clk or posedge rst) begin
    if (rst) edge_cnt <= 0;
    else     edge_cnt <= edge_cnt + 1;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] exp_word(input int k, input logic [31:0] c, s, f);
    if (k == 0)      return c;
    else if (k == 1) return s;
    else if (k == 2) return f;
    else if (k < 35) return 32'(3 * (k - 3));
    else if (k == 35) return 32'd5;
    else             return 32'd0;
  endfunction

  function automatic logic [1:0] exp_tag(input int k);
    if (k < 3)       return 2'd0;
    else if (k < 35) return 2'd1;
    else             return 2'd2;
  endfunction

  // Addresses point at word k+1 while word k is presented.
  function automatic logic [31:0] exp_raddr(input int k);
    if (k + 1 >= 3 && k + 1 < 35) return 32'(k + 1 - 3);
    else                          return 32'd0;
  endfunction

  function automatic logic [31:0] exp_maddr(input int k);
    if (k + 1 >= 35 && k + 1 < 43) return 32'(4 * (k + 1 - 35));
    else                            return 32'd0;
  endfunction

  task automatic check_reset_outputs(input string pfx);
    chk({pfx, "_valid"}, dif.out_valid_o, 0);
    chk({pfx, "_data"}, dif.out_data_o, 0);
    chk({pfx, "_tag"}, dif.out_tag_o, 0);
    chk({pfx, "_last"}, dif.out_last_o, 0);
    chk({pfx, "_busy"}, busy, 0);
    chk({pfx, "_raddr"}, reg_addr, 0);
    chk({pfx, "_maddr"}, mem_addr, 0);
    chk({pfx, "_cyc"}, cyc, 0);
    chk({pfx, "_stl"}, stl, 0);
    chk({pfx, "_fl"}, fl, 0);
  endtask

  task automatic request();
    chk("req_idle_valid", dif.out_valid_o, 0);
    dump_req = 1'b1;
    dif.out_ready_i = 1'b1;
    @(negedge clk);
    dump_req = 1'b0;
  endtask

  // Called at the negedge where the first word is visible. mode 0: ready tied high;
  // mode 1: ready 1,0,0,1 repeating. Stops early when stop_k words have been taken.
  task automatic run_dump(input logic [31:0] c, s, f, input int mode, input int pulse_at,
                          input bit hold, input int stop_k);
    int k = 0;
    int n = 0;
    int nlow = 0;
    bit rdy;
    while (k < stop_k && n < 300) begin
      rdy = (mode == 0) ? 1'b1 : ((n % 4 == 0) || (n % 4 == 3));
      dif.out_ready_i = rdy;
      dump_req = hold || (k == pulse_at);
      chk($sformatf("valid_w%0d", k), dif.out_valid_o, 1);
      chk($sformatf("busy_w%0d", k), busy, 1);
      chk($sformatf("data_w%0d", k), dif.out_data_o, exp_word(k, c, s, f));
      chk($sformatf("tag_w%0d", k), dif.out_tag_o, exp_tag(k));
      chk($sformatf("last_w%0d", k), dif.out_last_o, (k == 42));
      chk($sformatf("raddr_w%0d", k), reg_addr, exp_raddr(k));
      chk($sformatf("maddr_w%0d", k), mem_addr, exp_maddr(k));
      if (rdy) k++;
      else     nlow++;
      @(negedge clk);
      n++;
    end
    chk("dump_progress", k, stop_k);
    if (stop_k == 43) begin
      chk("dump_cycles", n, 43 + nlow);
      chk("end_valid", dif.out_valid_o, 0);
      chk("end_busy", busy, 0);
      chk("end_last", dif.out_last_o, 0);
    end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) regs[i] = 32'(3 * i);
    for (int i = 0; i < 8; i++)  mem[i] = 32'd0;
    mem[0] = 32'd5;
    rst = 1'b1; rst_w = 1'b1;
    stall = 1'b0; flush = 1'b0; dump_req = 1'b0;
    dif.out_ready_i = 1'b1;
    wif.out_ready_i = 1'b1;
    repeat (2) @(negedge clk);
    check_reset_outputs("rst");
    rst = 1'b0;

    // Stall on edges 2..6, flush on edges 6..7: edge 6 counts only as a flush.
    for (int e = 1; e <= 20; e++) begin
      stall = (e >= 2 && e <= 6);
      flush = (e == 6 || e == 7);
      @(negedge clk);
    end
    stall = 1'b0; flush = 1'b0;
    chk("cnt_cycle", cyc, 20);
    chk("cnt_stall", stl, 4);
    chk("cnt_flush", fl, 2);

    request();
    run_dump(32'd20, 32'd4, 32'd2, 0, -1, 1'b0, 43);

    // Back-pressure with a request pulse mid-dump that must be ignored.
    snap = edge_cnt;
    request();
    run_dump(snap, 32'd4, 32'd2, 1, 10, 1'b0, 43);
    for (int i = 0; i < 3; i++) begin
      chk("ignored_req_valid", dif.out_valid_o, 0);
      chk("ignored_req_busy", busy, 0);
      @(negedge clk);
    end

    // Request held high: one idle cycle, then a new dump starts.
    snap = edge_cnt;
    request();
    dump_req = 1'b1;
    run_dump(snap, 32'd4, 32'd2, 0, -1, 1'b1, 43);
    snap = edge_cnt;
    @(negedge clk);
    dump_req = 1'b0;
    run_dump(snap, 32'd4, 32'd2, 0, -1, 1'b0, 20);

    // Asynchronous reset while word 20 is presented.
    rst = 1'b1;
    #1;
    check_reset_outputs("midrst");
    @(negedge clk);
    rst = 1'b0;
    repeat (7) @(negedge clk);
    request();
    run_dump(32'd7, 32'd0, 32'd0, 0, -1, 1'b0, 43);

    rst_w = 1'b0;
    repeat (17) @(negedge clk);
    chk("wrap_cycle", cyc_w, 1);
    chk("wrap_stall", stl_w, 0);
    chk("wrap_flush", fl_w, 0);
    chk("wrap_valid", wif.out_valid_o, 0);
    chk("wrap_busy", busy_w, 0);
    chk("wrap_data", {wif.out_data_o, wif.out_tag_o, wif.out_last_o}, 0);
    chk("wrap_addr", {mem_addr_w, reg_addr_w}, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dbg_state_dumper.md
# dbg_state_dumper

On-chip debug readout unit for the pipelined CPU. It counts cycles, stalls and flushes in hardware. On request it streams a frozen snapshot of those counters, all 32 architectural registers and the first 8 data-memory words over a valid/ready port, so hosts and benches consume CPU state without hierarchical peeks. It attaches to a spare register-file read port and a spare data-memory read port.

## Interface
- NUM_REGS, 32: register words dumped, indices 0..NUM_REGS-1.
- NUM_MEM_WORDS, 8: data-memory words dumped, byte addresses 0, 4, ..., 4*(NUM_MEM_WORDS-1).
- CNT_W, 32: width of each performance counter.
- clk_i  in  1  single clock, all state on rising edge.
- rst_i  in  1  reset, asynchronous, active-high.
- stall_i  in  1  hazard-detection stall asserted this cycle.
- flush_i  in  1  control flush asserted this cycle.
- dump_req_i  in  1  dump request, sampled only in IDLE.
- busy_o  out  1  high from the cycle after request acceptance until the last word's handshake.
- reg_addr_o  out  5  register-file read address; combinational read data returns same cycle.
- reg_data_i  in  32  register-file read data.
- mem_addr_o  out  32  word-aligned data-memory byte address.
- mem_data_i  in  32  little-endian word {m[a+3],m[a+2],m[a+1],m[a]}, combinational.
- out_valid_o  out  1  output word valid.
- out_ready_i  in  1  consumer ready.
- out_data_o  out  32  output word; counters are zero-extended or truncated to 32.
- out_tag_o  out  2  word class: 0 counter, 1 register, 2 memory.
- out_last_o  out  1  marks the final word of a dump.
- cycle_cnt_o, stall_cnt_o, flush_cnt_o  out  CNT_W  live counter values.

## Operation
- Counter update rules:
  - cycle_cnt increments every cycle.
  - stall_cnt increments when stall_i && !flush_i. A stall coincident with a flush is not counted as a stall.
  - flush_cnt increments when flush_i.
  - All three wrap modulo 2^CNT_W.
- FSM states: IDLE, CNT, REG, MEM. A word index idx is held alongside the state.
- IDLE: when dump_req_i is high, the unit captures cycle/stall/flush snapshots using their pre-increment values on that edge. It then moves to CNT with idx=0 and loads out_data_o with snap_cycle.
- Output register: a word is loaded on entry and on every handshake (out_valid_o && out_ready_i). out_data_o, out_tag_o and out_last_o stay stable while out_valid_o && !out_ready_i.
- Word order, 3+NUM_REGS+NUM_MEM_WORDS words (43 at default):
  - CNT idx 0..2: snap_cycle, snap_stall, snap_flush.
  - REG idx 0..NUM_REGS-1: register idx.
  - MEM idx 0..NUM_MEM_WORDS-1: memory word at 4*idx.
- Address outputs always point at the next word to be loaded:
  - reg_addr_o = next register index, else 0.
  - mem_addr_o = 4 × next memory index, else 0.
  - Register and memory data are sampled at the load edge, not at request time. Only the counters are frozen.
- Last word: on its handshake the unit returns to IDLE, drops out_valid_o and clears busy_o and out_last_o.
- dump_req_i in CNT/REG/MEM is ignored and is not queued.
- Counters keep running during a dump.

## Timing
- Reset values: all counters 0, snapshots 0, state IDLE, out_valid_o=0, out_data_o=0, out_tag_o=0, out_last_o=0, busy_o=0, reg_addr_o=0, mem_addr_o=0.
- Request latency: dump_req_i high at edge N makes out_valid_o high after edge N, i.e. the first word is visible in cycle N+1.
- Throughput: one word per cycle while out_ready_i is high. A full dump with ready tied high keeps busy_o high for exactly 43 cycles.
- Back-pressure: each cycle of out_ready_i low adds exactly one cycle. No word is dropped or duplicated.
- Re-request: dump_req_i held high continuously starts a new dump the cycle after returning to IDLE, giving one idle cycle between dumps.
- Reset mid-dump: rst_i takes effect immediately and asynchronously; all outputs go to their reset values, and no partial-dump state survives.
- Counter wrap: at CNT_W=4, cycle_cnt goes 15 to 0 without affecting other state.

## Test plan
- Counting: stall_i=1 for 5 cycles, flush_i=1 for 2 cycles, with one cycle where both are high, then dump at cycle 20 -> words 0..2 = 20, 4, 2, tag 0.
- Full dump: register x(i)=i*3, memory word0=5 and others 0, out_ready_i=1 -> 43 words in 43 consecutive cycles. Register words carry tag 1 and equal 3*i. First memory word = 5 with mem_addr_o=0 at its load. out_last_o only on word 42.
- Back-pressure: out_ready_i toggles 1,0,0,1 repeatedly -> the sequence is identical to the full-dump case, and data is stable on every stalled cycle.
- Ignored request: pulse dump_req_i at word 10 -> exactly 43 words, then IDLE with busy_o=0.
- Reset mid-dump: assert rst_i during word 20 -> out_valid_o=0 and counters 0 immediately. A new request afterward returns snap_cycle equal to the cycles counted since reset release.
- Wrap: CNT_W=4 with 17 cycles run -> cycle_cnt_o=1.
